// File: rtl/nubus_pkg.sv
// Shared types and helpers for the NuBus slave: status codes, FSM states and
// byte-lane decode.
package nubus_pkg;

  localparam logic [1:0] StatOk      = 2'b00;
  localparam logic [1:0] StatErr     = 2'b01;
  localparam logic [1:0] StatTimeout = 2'b10;
  localparam logic [1:0] StatRetry   = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StWdat,
    StReq,
    StAck
  } state_e;

  // Byte enables from the transfer size (byte vs word/half) and AD[1:0].
  function automatic logic [3:0] ben_decode(input logic byte_acc, input logic [1:0] lane);
    logic [3:0] ben;
    if (byte_acc) begin
      ben = 4'b0001 << lane;
    end else begin
      unique case (lane)
        2'b11:   ben = 4'b1111;
        2'b00:   ben = 4'b0011;
        2'b10:   ben = 4'b1100;
        default: ben = 4'b0000;
      endcase
    end
    return ben;
  endfunction

endpackage

// File: rtl/nubus_slave_decode.sv
// START-cycle decode: slot/super-slot address match, direction, byte lanes and
// detection of the unsupported block-transfer encoding.
module nubus_slave_decode
  import nubus_pkg::*;
#(
  parameter bit SUPER_EN = 1'b1
) (
  input  logic [3:0] idn_i,
  input  logic [7:0] adn_hi_i,
  input  logic [1:0] adn_lo_i,
  input  logic       tm1n_i,
  input  logic       tm0n_i,
  output logic       hit_o,
  output logic       write_o,
  output logic       unsupported_o,
  output logic [3:0] ben_o
);

  logic [3:0] id;
  logic [7:0] a_hi;
  logic [1:0] a_lo;
  logic       slot_hit;
  logic       super_hit;

  assign id   = ~idn_i;
  assign a_hi = ~adn_hi_i;
  assign a_lo = ~adn_lo_i;

  assign slot_hit  = (a_hi == {4'hF, id});
  // IDs 0 and F would alias the slot space and the unused low region.
  assign super_hit = SUPER_EN && (a_hi[7:4] == id) && (id != 4'h0) && (id != 4'hF);

  assign hit_o         = slot_hit | super_hit;
  assign write_o       = ~tm1n_i;
  assign unsupported_o = tm0n_i && (a_lo == 2'b01);
  assign ben_o         = ben_decode(~tm0n_i, a_lo);

endmodule

// File: rtl/nubus_slave.sv
// NuBus responder: accepts single-beat reads/writes to this slot, runs them on
// the local memory port and terminates with a one-cycle ACK plus status.
module nubus_slave
  import nubus_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 200,
  parameter bit          SUPER_EN = 1'b1
) (
  input  logic        nub_clkn,
  input  logic        nub_reset,
  input  logic [3:0]  nub_idn,
  input  logic        nub_startn,
  input  logic        nub_ackn,
  input  logic        nub_tm1n,
  input  logic        nub_tm0n,
  input  logic [31:0] nub_adn,
  output logic        slv_ackn_o,
  output logic        slv_tm1n_o,
  output logic        slv_tm0n_o,
  output logic [31:0] slv_adn_o,
  output logic        slv_ad_oe_o,
  output logic        mem_valid_o,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_ben_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic        mem_err_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned     CntW   = $clog2(WAIT_MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(WAIT_MAX);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            ackn_q, tm1n_q, tm0n_q, oe_q, valid_q, write_q;
  logic [31:0]     adn_q, addr_q, wdata_q;
  logic [3:0]      ben_q;

  logic [31:0] a;
  logic        start, hit, dec_write, unsupported;
  logic [3:0]  dec_ben;

  assign a     = ~nub_adn;
  // Attention cycles assert ACK alongside START and must never open a transaction.
  assign start = ~nub_startn & nub_ackn;

  nubus_slave_decode #(
    .SUPER_EN(SUPER_EN)
  ) u_decode (
    .idn_i        (nub_idn),
    .adn_hi_i     (nub_adn[31:24]),
    .adn_lo_i     (nub_adn[1:0]),
    .tm1n_i       (nub_tm1n),
    .tm0n_i       (nub_tm0n),
    .hit_o        (hit),
    .write_o      (dec_write),
    .unsupported_o(unsupported),
    .ben_o        (dec_ben)
  );

  always_ff @(posedge nub_clkn or posedge nub_reset) begin
    if (nub_reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ackn_q  <= 1'b1;
      tm1n_q  <= 1'b1;
      tm0n_q  <= 1'b1;
      adn_q   <= '1;
      oe_q    <= 1'b0;
      valid_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      ben_q   <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && hit) begin
            if (unsupported) begin
              state_q          <= StAck;
              ackn_q           <= 1'b0;
              {tm1n_q, tm0n_q} <= ~StatErr;
            end else begin
              addr_q  <= {a[31:2], 2'b00};
              ben_q   <= dec_ben;
              write_q <= dec_write;
              if (dec_write) begin
                state_q <= StWdat;
              end else begin
                state_q <= StReq;
                valid_q <= 1'b1;
                cnt_q   <= '0;
              end
            end
          end
        end
        StWdat: begin
          wdata_q <= a;
          state_q <= StReq;
          valid_q <= 1'b1;
          cnt_q   <= '0;
        end
        StReq: begin
          if (mem_ready_i) begin
            state_q          <= StAck;
            valid_q          <= 1'b0;
            ackn_q           <= 1'b0;
            {tm1n_q, tm0n_q} <= mem_err_i ? ~StatErr : ~StatOk;
            if (!write_q && !mem_err_i) begin
              adn_q <= ~mem_rdata_i;
              oe_q  <= 1'b1;
            end
          end else if (cnt_q + CntW'(1) == CntMax) begin
            state_q          <= StAck;
            valid_q          <= 1'b0;
            ackn_q           <= 1'b0;
            {tm1n_q, tm0n_q} <= ~StatRetry;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StAck: begin
          state_q <= StIdle;
          ackn_q  <= 1'b1;
          tm1n_q  <= 1'b1;
          tm0n_q  <= 1'b1;
          adn_q   <= '1;
          oe_q    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign slv_ackn_o  = ackn_q;
  assign slv_tm1n_o  = tm1n_q;
  assign slv_tm0n_o  = tm0n_q;
  assign slv_adn_o   = adn_q;
  assign slv_ad_oe_o = oe_q;
  assign mem_valid_o = valid_q;
  assign mem_write_o = write_q;
  assign mem_addr_o  = addr_q;
  assign mem_ben_o   = ben_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_nubus_slave.sv
// Directed bench for nubus_slave: table of single transactions plus
// hand-written reset-during-request sequence.
module tb_nubus_slave;

  logic        clk = 1'b0;
  logic        nub_reset;
  logic [3:0]  nub_idn;
  logic        nub_startn, nub_ackn, nub_tm1n, nub_tm0n;
  logic [31:0] nub_adn;
  logic        slv_ackn_o, slv_tm1n_o, slv_tm0n_o, slv_ad_oe_o;
  logic [31:0] slv_adn_o;
  logic        mem_valid_o, mem_write_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_ben_o;
  logic        mem_ready_i, mem_err_i;
  logic [31:0] mem_rdata_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nubus_slave #(
    .WAIT_MAX(4),
    .SUPER_EN(1'b1)
  ) dut (
    .nub_clkn   (clk),
    .nub_reset  (nub_reset),
    .nub_idn    (nub_idn),
    .nub_startn (nub_startn),
    .nub_ackn   (nub_ackn),
    .nub_tm1n   (nub_tm1n),
    .nub_tm0n   (nub_tm0n),
    .nub_adn    (nub_adn),
    .slv_ackn_o (slv_ackn_o),
    .slv_tm1n_o (slv_tm1n_o),
    .slv_tm0n_o (slv_tm0n_o),
    .slv_adn_o  (slv_adn_o),
    .slv_ad_oe_o(slv_ad_oe_o),
    .mem_valid_o(mem_valid_o),
    .mem_write_o(mem_write_o),
    .mem_addr_o (mem_addr_o),
    .mem_ben_o  (mem_ben_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i),
    .mem_err_i  (mem_err_i),
    .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        tm1;
    logic        tm0;
    logic        attn;
    int          waits;    // -1: local side never answers
    logic        err;
    logic [31:0] data;     // write data or read data
    int          exp_acks;
    int          exp_lat;  // clocks from START sample to ACK sample, 0 = none
    logic [1:0]  exp_st;
    int          exp_vcnt; // cycles with mem_valid_o high
    logic [3:0]  exp_ben;
    logic        exp_oe;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_rst(input string p);
    chk({p, "_ackn"}, {31'd0, slv_ackn_o}, 32'd1);
    chk({p, "_tmn"}, {30'd0, slv_tm1n_o, slv_tm0n_o}, 32'd3);
    chk({p, "_adn"}, slv_adn_o, 32'hFFFF_FFFF);
    chk({p, "_oe"}, {31'd0, slv_ad_oe_o}, 32'd0);
    chk({p, "_valid"}, {31'd0, mem_valid_o}, 32'd0);
    chk({p, "_write"}, {31'd0, mem_write_o}, 32'd0);
    chk({p, "_addr"}, mem_addr_o, 32'd0);
    chk({p, "_ben"}, {28'd0, mem_ben_o}, 32'd0);
    chk({p, "_wdata"}, mem_wdata_o, 32'd0);
  endtask

  task automatic bus_idle();
    nub_startn  = 1'b1;
    nub_ackn    = 1'b1;
    nub_tm1n    = 1'b1;
    nub_tm0n    = 1'b1;
    nub_adn     = '1;
    mem_ready_i = 1'b0;
    mem_err_i   = 1'b0;
    mem_rdata_i = '0;
  endtask

  task automatic run_vec(input vec_t v);
    int          acks = 0;
    int          lat = 0;
    int          vcnt = 0;
    logic [3:0]  ben_s = '0;
    logic        wr_s = 1'b0, oe_s = 1'b0;
    logic [31:0] addr_s = '0, wd_s = '0, adn_s = '0;
    logic [1:0]  st_s = '0;
    @(negedge clk);
    nub_adn    = ~v.addr;
    nub_tm1n   = ~v.tm1;
    nub_tm0n   = ~v.tm0;
    nub_startn = 1'b0;
    nub_ackn   = ~v.attn;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      nub_startn  = 1'b1;
      nub_ackn    = 1'b1;
      nub_adn     = (i == 1) ? ~v.data : 32'hFFFF_FFFF;
      mem_ready_i = 1'b0;
      mem_err_i   = 1'b0;
      mem_rdata_i = '0;
      if (mem_valid_o) begin
        vcnt++;
        if (vcnt == 1) begin
          ben_s  = mem_ben_o;
          wr_s   = mem_write_o;
          addr_s = mem_addr_o;
          wd_s   = mem_wdata_o;
        end
        if (v.waits >= 0 && vcnt == v.waits + 1) begin
          mem_ready_i = 1'b1;
          mem_err_i   = v.err;
          mem_rdata_i = v.data;
        end
      end
      if (!slv_ackn_o) begin
        acks++;
        if (lat == 0) begin
          lat   = i;
          st_s  = ~{slv_tm1n_o, slv_tm0n_o};
          oe_s  = slv_ad_oe_o;
          adn_s = slv_adn_o;
        end
      end
    end
    // A late local completion must not produce another ACK or request.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mem_ready_i = 1'b1;
      mem_rdata_i = 32'h1111_2222;
      chk({v.name, "_late_ackn"}, {31'd0, slv_ackn_o}, 32'd1);
      chk({v.name, "_late_valid"}, {31'd0, mem_valid_o}, 32'd0);
    end
    mem_ready_i = 1'b0;
    mem_rdata_i = '0;

    chk({v.name, "_acks"}, acks, v.exp_acks);
    chk({v.name, "_latency"}, lat, v.exp_lat);
    chk({v.name, "_valid_cycles"}, vcnt, v.exp_vcnt);
    if (v.exp_acks > 0) begin
      chk({v.name, "_status"}, {30'd0, st_s}, {30'd0, v.exp_st});
      chk({v.name, "_ad_oe"}, {31'd0, oe_s}, {31'd0, v.exp_oe});
      if (v.exp_oe) chk({v.name, "_rdata_bus"}, adn_s, ~v.data);
    end
    if (v.exp_vcnt > 0) begin
      chk({v.name, "_ben"}, {28'd0, ben_s}, {28'd0, v.exp_ben});
      chk({v.name, "_write"}, {31'd0, wr_s}, {31'd0, v.tm1});
      chk({v.name, "_addr"}, addr_s, {v.addr[31:2], 2'b00});
      if (v.tm1) chk({v.name, "_wdata"}, wd_s, v.data);
    end
  endtask

  initial begin
    //          name         addr          tm1   tm0   attn  wt  err   data           acks lat st     vc ben      oe
    vecs[0]  = '{"word_rd",  32'hF9000013, 1'b0, 1'b0, 1'b0, 0,  1'b0, 32'hDEADBEEF, 1, 2, 2'b00, 1, 4'b1111, 1'b1};
    vecs[1]  = '{"byte_wr",  32'hF9000102, 1'b1, 1'b1, 1'b0, 3,  1'b0, 32'h000000AA, 1, 6, 2'b00, 4, 4'b0100, 1'b0};
    vecs[2]  = '{"no_match", 32'hFA000000, 1'b0, 1'b0, 1'b0, 0,  1'b0, 32'h00000000, 0, 0, 2'b00, 0, 4'b0000, 1'b0};
    vecs[3]  = '{"attn",     32'hF9000000, 1'b0, 1'b0, 1'b1, 0,  1'b0, 32'h00000000, 0, 0, 2'b00, 0, 4'b0000, 1'b0};
    vecs[4]  = '{"retry",    32'hF9000013, 1'b0, 1'b0, 1'b0, -1, 1'b0, 32'h00000000, 1, 5, 2'b11, 4, 4'b1111, 1'b0};
    vecs[5]  = '{"err_rd",   32'hF9000023, 1'b0, 1'b0, 1'b0, 0,  1'b1, 32'h87654321, 1, 2, 2'b01, 1, 4'b1111, 1'b0};
    vecs[6]  = '{"block",    32'hF9000001, 1'b0, 1'b0, 1'b0, 0,  1'b0, 32'h00000000, 1, 1, 2'b01, 0, 4'b0000, 1'b0};
    vecs[7]  = '{"super_rd", 32'h90001234, 1'b0, 1'b0, 1'b0, 0,  1'b0, 32'h12345678, 1, 2, 2'b00, 1, 4'b0011, 1'b1};
    vecs[8]  = '{"half0_wr", 32'hF9000200, 1'b1, 1'b0, 1'b0, 1,  1'b0, 32'hCAFEF00D, 1, 4, 2'b00, 2, 4'b0011, 1'b0};
    vecs[9]  = '{"half1_rd", 32'hF9000032, 1'b0, 1'b0, 1'b0, 2,  1'b0, 32'h01020304, 1, 4, 2'b00, 3, 4'b1100, 1'b1};
    vecs[10] = '{"byte3_rd", 32'hF900000B, 1'b0, 1'b1, 1'b0, 0,  1'b0, 32'h5A5AA5A5, 1, 2, 2'b00, 1, 4'b1000, 1'b1};
    vecs[11] = '{"super_no", 32'h30000000, 1'b0, 1'b0, 1'b0, 0,  1'b0, 32'h00000000, 0, 0, 2'b00, 0, 4'b0000, 1'b0};

    nub_idn   = ~4'h9;
    nub_reset = 1'b1;
    bus_idle();
    repeat (3) @(negedge clk);
    chk_rst("reset");
    nub_reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 12; k++) run_vec(vecs[k]);

    // Reset pulsed while a read waits in REQ: outputs clear at once, no ACK.
    @(negedge clk);
    nub_adn    = ~32'hF9000013;
    nub_tm1n   = 1'b1;
    nub_tm0n   = 1'b1;
    nub_startn = 1'b0;
    @(negedge clk);
    bus_idle();
    @(negedge clk);
    chk("mid_rst_valid_before", {31'd0, mem_valid_o}, 32'd1);
    #2 nub_reset = 1'b1;
    #1 chk_rst("mid_rst");
    @(negedge clk);
    chk("mid_rst_hold_ackn", {31'd0, slv_ackn_o}, 32'd1);
    nub_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_ackn", {31'd0, slv_ackn_o}, 32'd1);
      chk("post_rst_valid", {31'd0, mem_valid_o}, 32'd0);
    end
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
